// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing from raw h/v sync pins and
// locks once two consecutive frames agree; reports pixel position while locked.
module vga_sync_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned H_MAX       = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic        locked,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_len,
  output logic [10:0] v_total,
  output logic [10:0] v_sync_len,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        err
);

  localparam logic [11:0] HMax = 12'(H_MAX);
  localparam logic [10:0] VMax = 11'h7ff;

  typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] h_meta_q, v_meta_q;
  logic        h_prev_q, v_prev_q, v_pend_q;
  logic [11:0] hc_q, hl_q;
  logic [10:0] vc_q, vl_q;
  logic [11:0] cap_ht_q, cap_hs_q;
  logic [10:0] cap_vt_q, cap_vs_q;
  logic        err_q, frame_start_q;

  logic        h_s, v_s, h_fall, v_fall, fs, h_to, v_to;
  logic [11:0] h_period;
  logic [10:0] v_period;
  logic        h_ok, v_ok, cap_match, cap_en, out_en, err_d;

  // Synchronizers idle high so reset never fakes a sync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_meta_q <= '1;
      v_meta_q <= '1;
      h_prev_q <= 1'b1;
      v_prev_q <= 1'b1;
    end else begin
      h_meta_q <= {h_meta_q[SYNC_STAGES-2:0], h_sync};
      v_meta_q <= {v_meta_q[SYNC_STAGES-2:0], v_sync};
      h_prev_q <= h_s;
      v_prev_q <= v_s;
    end
  end

  assign h_s      = h_meta_q[SYNC_STAGES-1];
  assign v_s      = v_meta_q[SYNC_STAGES-1];
  assign h_fall   = h_prev_q & ~h_s;
  assign v_fall   = v_prev_q & ~v_s;
  assign fs       = h_fall & (v_pend_q | v_fall);
  assign h_period = hc_q + 12'd1;
  assign v_period = vc_q + 11'd1;
  assign h_to     = (hc_q == HMax) & ~h_fall;
  assign v_to     = (vc_q == VMax) & ~fs;

  // The h_fall cycle itself is the first low clock of the new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q     <= '0;
      hl_q     <= '0;
      vc_q     <= '0;
      vl_q     <= '0;
      v_pend_q <= 1'b0;
    end else begin
      if (h_fall)            hc_q <= '0;
      else if (hc_q != HMax) hc_q <= hc_q + 12'd1;

      if (h_fall)                 hl_q <= 12'd1;
      else if (!h_s && hl_q != '1) hl_q <= hl_q + 12'd1;

      if (fs)                          vc_q <= '0;
      else if (h_fall && vc_q != VMax) vc_q <= vc_q + 11'd1;

      if (fs)                                 vl_q <= {10'd0, ~v_s};
      else if (h_fall && !v_s && vl_q != VMax) vl_q <= vl_q + 11'd1;

      if (fs)          v_pend_q <= 1'b0;
      else if (v_fall) v_pend_q <= 1'b1;
    end
  end

  assign h_ok      = (h_period == h_total) && (hl_q == h_sync_len);
  assign v_ok      = (v_period == v_total) && (vl_q == v_sync_len);
  assign cap_match = (h_period == cap_ht_q) && (hl_q == cap_hs_q) &&
                     (v_period == cap_vt_q) && (vl_q == cap_vs_q);

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    out_en  = 1'b0;
    err_d   = 1'b0;
    if (h_to || v_to) begin
      state_d = StSearch;
      err_d   = (state_q == StLocked);
    end else begin
      case (state_q)
        StSearch: if (fs) state_d = StMeasure;
        StMeasure: begin
          if (fs) begin
            cap_en  = 1'b1;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (fs) begin
            if (cap_match) begin
              out_en  = 1'b1;
              state_d = StLocked;
            end else begin
              cap_en = 1'b1;
            end
          end
        end
        StLocked: begin
          if ((h_fall && !h_ok) || (fs && !v_ok)) begin
            err_d   = 1'b1;
            state_d = StSearch;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StSearch;
      cap_ht_q      <= '0;
      cap_hs_q      <= '0;
      cap_vt_q      <= '0;
      cap_vs_q      <= '0;
      h_total       <= '0;
      h_sync_len    <= '0;
      v_total       <= '0;
      v_sync_len    <= '0;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      frame_start_q <= fs && (state_d == StLocked);
      if (cap_en) begin
        cap_ht_q <= h_period;
        cap_hs_q <= hl_q;
        cap_vt_q <= v_period;
        cap_vs_q <= vl_q;
      end
      if (out_en) begin
        h_total    <= h_period;
        h_sync_len <= hl_q;
        v_total    <= v_period;
        v_sync_len <= vl_q;
      end
    end
  end

  assign locked      = (state_q == StLocked);
  assign x           = locked ? hc_q : 12'd0;
  assign y           = locked ? vc_q : 11'd0;
  assign err         = err_q;
  assign frame_start = frame_start_q;

endmodule
